fft_input_framer: RTL and testbench
===================================

// Module: fft_input_framer
// PURPOSE
//  Upstream stage of the FFT computer: accepts raw 32-bit complex samples ({re[15:0],im[15:0]}),
//  buffers them in a small FIFO and emits them as fixed-length frames with a last-beat flag.
//  Output feeds the FFT core data slave (valid/ready/last).
//  On request, completes a partial frame with zero samples so the FFT never stalls mid-frame.
// PARAMETERS
//  DATA_W      32    sample width, {re,im} packed
//  FRAME_LEN   1024  samples per frame (transform length); >=2
//  CNT_W       10    sample counter width; 2**CNT_W >= FRAME_LEN
//  FIFO_DEPTH  16    input buffer entries; power of 2, >=2
// PORTS
//  i_clk           in   1       clock; all logic on rising edge
//  i_rst_n         in   1       synchronous reset, active low
//  i_data          in   DATA_W  upstream sample
//  i_data_valid    in   1       upstream sample valid
//  o_data_ready    out  1       framer can accept sample this cycle
//  i_flush         in   1       single-cycle request: finish current frame with zeros
//  o_data          out  DATA_W  sample to FFT core
//  o_data_valid    out  1       o_data valid
//  o_data_last     out  1       high on the final sample of each frame
//  i_data_ready    in   1       FFT core accepts o_data this cycle
//  o_busy          out  1       high while state != STREAM
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, sample counter 0, state STREAM; applies mid-frame, discards
//    FIFO contents and any partial frame.
//  - Input handshake: write when i_data_valid && o_data_ready.
//    o_data_ready is a register: 1 iff state==STREAM && FIFO has >=2 free entries after this cycle's
//    traffic, so no combinational path from i_data_ready.
//  - Output handshake: beat on o_data_valid && i_data_ready. Once asserted, o_data_valid,
//    o_data and o_data_last hold stable until the beat.
//  - Output register is fed from the FIFO. First sample written into an empty framer appears on
//    o_data at the edge after the write (1-cycle latency). Full throughput: 1 beat/cycle when both sides stream.
//  - Counter increments on every output beat.
//    o_data_last = (counter == FRAME_LEN-1); on that beat counter wraps to 0.
//  - States:
//    STREAM: output from FIFO.
//      i_flush && (counter!=0 || FIFO/out-reg non-empty) -> DRAIN.
//      i_flush with no partial data: ignored.
//    DRAIN: input blocked; output keeps emitting buffered samples.
//      When FIFO and output register are empty: -> STREAM if counter==0, else -> PAD.
//    PAD: o_data=0, o_data_valid=1 until the last-beat handshake, then -> STREAM.
//  - i_flush while in DRAIN or PAD: ignored (no queuing).
//  - Frame boundary is counter-driven only; a flush that drains exactly to counter==0 emits no padding.
//  - Simultaneous FIFO read+write when full: write is already blocked by the registered
//    o_data_ready. Read+write when empty: sample passes through in 1 cycle.
//  - Downstream stall: no sample loss or duplication; FIFO fills, then o_data_ready drops.
// CONFIGURATION
//  FRAMER_STATUS_EN defined:
//    adds ports o_frame_cnt (out, 16, frames completed, i.e. last beats, wraps at 2**16)
//    and o_pad_cnt (out, 16, zero samples inserted, saturates at 16'hFFFF); both reset to 0.
//  Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING  (bench: FRAME_LEN=8, CNT_W=3, FIFO_DEPTH=4)
//  - Reset: i_rst_n=0 for 2 cycles -> o_data_valid=0, o_data_last=0, o_busy=0, o_data=0;
//    o_data_ready=1 one cycle after release.
//  - Streaming: 16 samples 1..16, i_data_ready=1 -> 16 beats in order, 1 cycle after each input;
//    o_data_last on samples 8 and 16 only.
//  - Backpressure: i_data_ready=0 with valid input -> o_data_ready drops after FIFO_DEPTH-1+1
//    samples held; release -> all samples out in order, none dropped or duplicated.
//  - Flush: 3 samples A,B,C then i_flush -> A,B,C followed by 5 zeros, last on 5th zero; o_busy
//    high throughout; o_data_ready=0 until return to STREAM.
//  - Flush at boundary: exactly 8 samples then i_flush -> 8 beats, no zeros; i_flush with empty
//    framer -> o_busy stays 0.
//  - Reset mid-frame: 5 samples out, assert reset -> next frame restarts counter;
//    o_data_last on its 8th beat.
//    With FRAMER_STATUS_EN: after the flush scenario o_frame_cnt=1, o_pad_cnt=5.

Source files
------------

// File: rtl/fft_input_framer.sv
// FFT input framer: FIFO-buffered samples out as fixed-length frames with last flag.
// Optional FRAMER_STATUS_EN adds frame and pad counters.
module fft_input_framer #(
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_data_last,
  input  logic              i_data_ready,
  output logic              o_busy
`ifdef FRAMER_STATUS_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_pad_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;

  localparam logic [1:0] ST_STREAM = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_PAD    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [FW-1:0]    FILL_LIM = FW'(FIFO_DEPTH - 2);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic wr;
  logic rd;
  logic beat;
  logic out_free;
  logic fifo_empty;
  logic at_last;
  logic partial;
  logic pad_load;
  logic ready_nxt;

  assign wr         = i_data_valid && o_data_ready;
  assign fifo_empty = (fill == '0);
  assign beat       = o_data_valid && i_data_ready;
  assign out_free   = !o_data_valid || i_data_ready;
  assign rd         = out_free && !fifo_empty && (state != ST_PAD);
  assign at_last    = (cnt == CNT_LAST);
  assign partial    = (cnt != '0) || !fifo_empty || o_data_valid;

  assign o_data_last = o_data_valid && at_last;
  assign o_busy      = (state != ST_STREAM);

  always_comb begin
    fill_nxt = fill + FW'(wr) - FW'(rd);
    cnt_nxt  = cnt;
    if (beat) cnt_nxt = at_last ? '0 : cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    pad_load  = 1'b0;
    unique case (state)
      ST_STREAM: begin
        if (i_flush && partial) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // nothing left to read and the output slot empties this cycle
        if (fifo_empty && out_free) begin
          if (cnt_nxt == '0) begin
            state_nxt = ST_STREAM;
          end else begin
            state_nxt = ST_PAD;
            pad_load  = 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (beat) begin
          if (at_last) state_nxt = ST_STREAM;
          else         pad_load  = 1'b1;
        end
      end
      default: state_nxt = ST_STREAM;
    endcase
  end

  assign ready_nxt = (state_nxt == ST_STREAM) && (fill_nxt <= FILL_LIM);

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      cnt          <= '0;
      state        <= ST_STREAM;
      o_data_ready <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      fill         <= fill_nxt;
      cnt          <= cnt_nxt;
      state        <= state_nxt;
      o_data_ready <= ready_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else if (rd) begin
      o_data       <= mem[rd_ptr];
      o_data_valid <= 1'b1;
    end else if (pad_load) begin
      o_data       <= '0;
      o_data_valid <= 1'b1;
    end else if (beat) begin
      o_data_valid <= 1'b0;
    end
  end

`ifdef FRAMER_STATUS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_frame_cnt <= '0;
      o_pad_cnt   <= '0;
    end else begin
      if (beat && at_last) o_frame_cnt <= o_frame_cnt + 1'b1;
      if (beat && (state == ST_PAD) && (o_pad_cnt != 16'hFFFF))
        o_pad_cnt <= o_pad_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer (FRAME_LEN=8, FIFO_DEPTH=4).
// Build with FRAMER_STATUS_EN to also cover the status counters.
module tb_fft_input_framer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        o_data_ready;
  logic        i_flush = 1'b0;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_data_last;
  logic        i_data_ready = 1'b1;
  logic        o_busy;
`ifdef FRAMER_STATUS_EN
  logic [15:0] o_frame_cnt;
  logic [15:0] o_pad_cnt;
`endif

  int checks = 0;
  int fails = 0;
  logic [31:0] qd [$];
  logic        ql [$];

  fft_input_framer #(
    .DATA_W(32), .FRAME_LEN(8), .CNT_W(3), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_data(i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .i_flush(i_flush),
    .o_data(o_data),
    .o_data_valid(o_data_valid),
    .o_data_last(o_data_last),
    .i_data_ready(i_data_ready),
    .o_busy(o_busy)
`ifdef FRAMER_STATUS_EN
    ,
    .o_frame_cnt(o_frame_cnt),
    .o_pad_cnt(o_pad_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (i_rst_n && o_data_valid && i_data_ready) begin
      qd.push_back(o_data);
      ql.push_back(o_data_last);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_data_valid = 1'b0;
    i_flush = 1'b0;
    i_data = '0;
    i_data_ready = 1'b1;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    qd.delete();
    ql.delete();
  endtask

  task automatic wait_beats(input int n, input int lim);
    for (int i = 0; i < lim && qd.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_data_valid = 1'b0;
    i_flush = 1'b0;
    tick();
    tick();
    checks++;
    if (o_data_valid !== 1'b0) begin
      fails++; $display("FAIL rst_valid: got %b want 0", o_data_valid);
    end
    checks++;
    if (o_data_last !== 1'b0) begin
      fails++; $display("FAIL rst_last: got %b want 0", o_data_last);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy: got %b want 0", o_busy);
    end
    checks++;
    if (o_data !== 32'h0) begin
      fails++; $display("FAIL rst_data: got %h want 0", o_data);
    end
    checks++;
    if (o_data_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready_in: got %b want 0", o_data_ready);
    end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_data_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready_out: got %b want 1", o_data_ready);
    end
    qd.delete();
    ql.delete();
  endtask

  task automatic test_streaming();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (o_data_ready !== 1'b1) begin
        fails++; $display("FAIL stream_ready[%0d]: got %b want 1", k, o_data_ready);
      end
      i_data = 32'(k + 1);
      i_data_valid = 1'b1;
      tick();
      if (k > 0) begin
        checks++;
        if (o_data_valid !== 1'b1 || o_data !== 32'(k)) begin
          fails++;
          $display("FAIL stream_lat[%0d]: got %b/%h want 1/%h", k, o_data_valid, o_data, 32'(k));
        end
      end
    end
    i_data_valid = 1'b0;
    tick();
    checks++;
    if (o_data !== 32'd16 || o_data_last !== 1'b1) begin
      fails++; $display("FAIL stream_tail: got %h/%b want 10/1", o_data, o_data_last);
    end
    wait_beats(16, 10);
    tick();
    tick();
    checks++;
    if (qd.size() !== 16) begin
      fails++; $display("FAIL stream_count: got %0d want 16", qd.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (qd[i] !== 32'(i + 1) || ql[i] !== (i == 7 || i == 15)) begin
          fails++;
          $display("FAIL stream_beat[%0d]: got %h/%b want %h/%b",
                   i, qd[i], ql[i], 32'(i + 1), (i == 7 || i == 15));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset();
    i_data_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_data_ready) begin
        i_data = 32'd101 + 32'(acc);
        i_data_valid = 1'b1;
        tick();
        acc++;
      end else begin
        i_data_valid = 1'b0;
        tick();
      end
    end
    i_data_valid = 1'b0;
    checks++;
    if (acc !== 4) begin
      fails++; $display("FAIL bp_accepted: got %0d want 4", acc);
    end
    checks++;
    if (o_data_ready !== 1'b0) begin
      fails++; $display("FAIL bp_ready: got %b want 0", o_data_ready);
    end
    checks++;
    if (o_data_valid !== 1'b1 || o_data !== 32'd101) begin
      fails++; $display("FAIL bp_hold: got %b/%h want 1/65", o_data_valid, o_data);
    end
    i_data_ready = 1'b1;
    wait_beats(4, 10);
    tick();
    tick();
    checks++;
    if (qd.size() !== 4) begin
      fails++; $display("FAIL bp_count: got %0d want 4", qd.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qd[i] !== 32'd101 + 32'(i) || ql[i] !== 1'b0) begin
          fails++;
          $display("FAIL bp_beat[%0d]: got %h/%b want %h/0", i, qd[i], ql[i], 32'd101 + 32'(i));
        end
      end
    end
    checks++;
    if (o_data_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready_back: got %b want 1", o_data_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp [8];
    int bad;
    int n;
    exp = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_data = exp[i];
      i_data_valid = 1'b1;
      tick();
    end
    i_data_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    bad = 0;
    n = 0;
    while (qd.size() < 8 && n < 30) begin
      if (o_busy !== 1'b1 || o_data_ready !== 1'b0) bad++;
      tick();
      n++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL flush_busy: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (o_busy !== 1'b0 || o_data_ready !== 1'b1) begin
      fails++; $display("FAIL flush_exit: got busy %b rdy %b want 0/1", o_busy, o_data_ready);
    end
    tick();
    tick();
    checks++;
    if (qd.size() !== 8) begin
      fails++; $display("FAIL flush_count: got %0d want 8", qd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (qd[i] !== exp[i] || ql[i] !== (i == 7)) begin
          fails++;
          $display("FAIL flush_beat[%0d]: got %h/%b want %h/%b", i, qd[i], ql[i], exp[i], (i == 7));
        end
      end
    end
`ifdef FRAMER_STATUS_EN
    checks++;
    if (o_frame_cnt !== 16'd1) begin
      fails++; $display("FAIL frame_cnt: got %0d want 1", o_frame_cnt);
    end
    checks++;
    if (o_pad_cnt !== 16'd5) begin
      fails++; $display("FAIL pad_cnt: got %0d want 5", o_pad_cnt);
    end
`endif
  endtask

  task automatic test_flush_boundary();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      i_data = 32'h200 + 32'(i);
      i_data_valid = 1'b1;
      tick();
    end
    i_data_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      fails++; $display("FAIL bnd_busy: got %b want 1", o_busy);
    end
    for (int i = 0; i < 20 && o_busy; i++) tick();
    tick();
    tick();
    tick();
    checks++;
    if (qd.size() !== 8) begin
      fails++; $display("FAIL bnd_count: got %0d want 8", qd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (qd[i] !== 32'h200 + 32'(i) || ql[i] !== (i == 7)) begin
          fails++;
          $display("FAIL bnd_beat[%0d]: got %h/%b want %h/%b",
                   i, qd[i], ql[i], 32'h200 + 32'(i), (i == 7));
        end
      end
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      fails++; $display("FAIL empty_flush_busy: got %b want 0", o_busy);
    end
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_data_valid !== 1'b0 || qd.size() !== 8) begin
      fails++;
      $display("FAIL empty_flush_idle: got busy %b vld %b n %0d want 0/0/8",
               o_busy, o_data_valid, qd.size());
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_data = 32'h300 + 32'(i);
      i_data_valid = 1'b1;
      tick();
    end
    i_data_valid = 1'b0;
    wait_beats(5, 10);
    checks++;
    if (qd.size() !== 5) begin
      fails++; $display("FAIL mid_pre_count: got %0d want 5", qd.size());
    end
    do_reset();
    checks++;
    if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL mid_rst_out: got vld %b busy %b want 0/0", o_data_valid, o_busy);
    end
    for (int i = 0; i < 8; i++) begin
      i_data = 32'h400 + 32'(i);
      i_data_valid = 1'b1;
      tick();
    end
    i_data_valid = 1'b0;
    wait_beats(8, 10);
    checks++;
    if (qd.size() !== 8) begin
      fails++; $display("FAIL mid_count: got %0d want 8", qd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (qd[i] !== 32'h400 + 32'(i) || ql[i] !== (i == 7)) begin
          fails++;
          $display("FAIL mid_beat[%0d]: got %h/%b want %h/%b",
                   i, qd[i], ql[i], 32'h400 + 32'(i), (i == 7));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_boundary();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
